// File: rtl/gate_self_test_ctrl_if.sv
// Gate-unit stimulus/response bus between the self-test controller and the gate unit under test.
interface gate_self_test_ctrl_if;
    logic       a_out;
    logic       b_out;
    logic [6:0] gate_out;

    modport master (
        output a_out,
        output b_out,
        input  gate_out
    );

    modport slave (
        input  a_out,
        input  b_out,
        output gate_out
    );
endinterface

// File: rtl/gate_self_test_ctrl.sv
// Built-in self-test sequencer for a 2-input gate unit.
// Walks {a,b} = 00..11, lets the unit settle, compares all seven results, and reports the first failure.
module gate_self_test_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2  // legal range 0..15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    gate_self_test_ctrl_if.master        gu,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [2:0]                   err_count,
    output logic [1:0]                   fail_vec,
    output logic [6:0]                   fail_mask
);

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned ERR_W     = 3;
    localparam int unsigned NUM_GATES = 7;
    localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(4);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(3);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   a_q;
    logic                   b_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic [ERR_W-1:0]       err_q;
    logic [IDX_W-1:0]       fvec_q;
    logic [NUM_GATES-1:0]   fmask_q;

    logic [NUM_GATES-1:0]   exp_c;
    logic [NUM_GATES-1:0]   diff_c;

    // Golden gate results for the vector currently on the bus.
    always_comb begin
        exp_c    = '0;
        exp_c[0] = a_q | b_q;
        exp_c[1] = a_q & b_q;
        exp_c[2] = ~a_q;
        exp_c[3] = ~(a_q & b_q);
        exp_c[4] = ~(a_q | b_q);
        exp_c[5] = a_q ^ b_q;
        exp_c[6] = ~(a_q ^ b_q);
        diff_c   = gu.gate_out ^ exp_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvec_q  <= '0;
            fmask_q <= '0;
        end else begin
            busy_q <= (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= APPLY;
                        idx_q   <= '0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fvec_q  <= '0;
                        fmask_q <= '0;
                    end
                end
                APPLY: begin
                    a_q   <= idx_q[1];
                    b_q   <= idx_q[0];
                    cnt_q <= CNT_W'(SETTLE_CYCLES);
                    state_q <= (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                end
                SETTLE: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    // Only the first failing vector is captured; later ones just count.
                    if (diff_c != '0) begin
                        if (err_q != ERR_MAX) begin
                            err_q <= err_q + ERR_W'(1);
                        end
                        if (err_q == '0) begin
                            fvec_q  <= {a_q, b_q};
                            fmask_q <= diff_c;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= APPLY;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    pass_q  <= (err_q == '0);
                    a_q     <= 1'b0;
                    b_q     <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gu.a_out  = a_q;
    assign gu.b_out  = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fvec_q;
    assign fail_mask = fmask_q;

endmodule
